sound_sequencer: RTL and testbench
==================================

SOUND_SEQUENCER -- requirements
Module: sound_sequencer

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning): NOTE_TICKS, 12500000, clk cycles per note length unit.
REQ-002 The block SHALL take GAP_TICKS, 250000, silent clk cycles inserted after every note.
REQ-003 The block SHALL take PRESCALE, 64, clk cycles per half-period unit.
REQ-004 The block SHALL have port clk, input, 1, system clock.
REQ-005 The block SHALL have port resetN, input, 1, reset, asynchronous, active-low.
REQ-006 The block SHALL have port playSound, input, 1, single-cycle request pulse from the game controller.
REQ-007 The block SHALL have port toneSel, input, 2, tone ID sampled with playSound: 0 = countdown beep, 1 = go beep, 2 = welcome melody, 3 = game-over.
REQ-008 The block SHALL have port mute, input, 1, level, forces audio silent.
REQ-009 The block SHALL have port soundOut, output, 1, square-wave audio.
REQ-010 The block SHALL have port busy, output, 1, high while a tone is in progress.
REQ-011 The block SHALL have port done, output, 1, one-cycle pulse when a tone finishes.

Function
REQ-012 The tone ROM SHALL hold 4 tones x 8 entries; each entry is {half[11:0], len[2:0]}, and len == 0 marks the end of the tone.
REQ-013 The ROM contents SHALL be, with entries listed as {half,len}:
- tone0 = {100,1};
- tone1 = {50,2};
- tone2 = {120,1}, {100,1}, {80,1}, {60,2};
- tone3 = {60,1}, {0,1}, {120,2}.
All unlisted entries SHALL be {0,0}.
REQ-014 The FSM SHALL have states IDLE, LOAD, PLAY, GAP and DONE.
REQ-015 In IDLE, playSound SHALL latch toneSel, set noteIdx to 0 and go to LOAD on the next cycle.
REQ-016 In LOAD, an entry with len == 0 SHALL go to DONE; otherwise the FSM SHALL load half, unitCnt = len and tickCnt = NOTE_TICKS-1, then go to PLAY.
REQ-017 In PLAY, tickCnt SHALL decrement every cycle; at 0 it SHALL reload, and unitCnt SHALL decrement.
REQ-018 PLAY SHALL go to GAP when tickCnt == 0 and unitCnt == 1, so that PLAY lasts exactly len*NOTE_TICKS cycles.
REQ-019 In GAP, soundOut SHALL be 0 for GAP_TICKS cycles; then noteIdx SHALL increment and the FSM SHALL go to LOAD, or to DONE if noteIdx was 7.
REQ-020 In DONE, done SHALL be 1 for one cycle; the FSM SHALL then go to IDLE, or to LOAD with the pending tone if a pending request exists.
REQ-021 In PLAY with half != 0, soundOut SHALL toggle every half*PRESCALE cycles, starting at 0 on PLAY entry.
REQ-022 When half == 0 (rest), soundOut SHALL stay 0.
REQ-023 The divider SHALL restart at each PLAY entry.
REQ-024 soundOut SHALL be 0 in IDLE, LOAD, GAP and DONE.
REQ-025 busy SHALL be 1 in LOAD, PLAY, GAP and DONE, and 0 only in IDLE.
REQ-026 Latency: a playSound pulse at cycle N SHALL give busy = 1 at N+1 and PLAY entry at N+2.
REQ-027 A playSound pulse while busy, including during DONE, SHALL set a one-deep pending flag and store toneSel; a later request SHALL overwrite the stored tone.
REQ-028 The current tone SHALL never be interrupted.
REQ-029 mute SHALL force soundOut to 0 combinationally; sequencing and the divider SHALL keep running.
REQ-030 playSound held high for several cycles in IDLE SHALL start one tone and register one pending request.

Reset
REQ-031 On resetN low, asynchronously, the FSM SHALL go to IDLE, and soundOut, busy, done, the pending flag, noteIdx and all counters SHALL go to 0.
REQ-032 Reset asserted during a tone SHALL abort the tone silently, with no done pulse.

Configuration
REQ-033 With SOUND_MELODY_EN defined, all ROM entries SHALL be used.
REQ-034 Without SOUND_MELODY_EN, GAP SHALL always go to DONE after the first note, so every tone plays entry 0 only and the ROM keeps 1 entry per tone.

Structure
REQ-035 sound_pkg SHALL hold the note_t struct, the TONE_ROM constant, the tone ID enum and the state enum.
REQ-036 Sub-module tone_gen SHALL contain the prescaled half-period divider, with inputs restart, half, enable and output wave.

Verification
Bench parameters: NOTE_TICKS=1000, GAP_TICKS=2, PRESCALE=1.
REQ-037 playSound with toneSel=0 -> busy for 1+1000+2+1+1 = 1005 cycles, 10 soundOut edges 100 cycles apart, then one done pulse.
REQ-038 toneSel=2 -> note half-periods of 120, 100, 80 and 60 cycles, with the last note 2000 cycles long, 2-cycle silences between notes, and done after the 4th note.
REQ-039 toneSel=3 -> the second note gives 1000 cycles of soundOut=0 while busy=1.
REQ-040 toneSel=1, then playSound with toneSel=0 at cycle 500 -> tone1 completes, done pulses, the FSM goes straight to LOAD, and tone0 follows with no IDLE cycle.
REQ-041 mute=1 during tone2 -> soundOut stays 0 and done arrives at the same cycle as in the unmuted case.
REQ-042 resetN low at cycle 300 of tone0 -> soundOut=0, busy=0 and no done pulse; the next playSound plays normally.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared types and tone table for the sound sequencer.
//
// Contents:
//   note_t    - one tone-table entry {half[11:0], len[2:0]}; len == 0 ends a tone
//   tone_e    - tone IDs as seen on toneSel
//   state_e   - sequencer FSM states
//   TONE_ROM  - tone table, NumTones x NotesPerTone entries
//
// Build option: SOUND_MELODY_EN keeps all 8 entries per tone. Without it only
// entry 0 of each tone is stored.
package sound_pkg;

    localparam int unsigned HalfW    = 12;
    localparam int unsigned LenW     = 3;
    localparam int unsigned NumTones = 4;

    typedef struct packed {
        logic [HalfW-1:0] half;
        logic [LenW-1:0]  len;
    } note_t;

    typedef enum logic [1:0] {
        ToneCountdown = 2'd0,
        ToneGo        = 2'd1,
        ToneWelcome   = 2'd2,
        ToneGameOver  = 2'd3
    } tone_e;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StPlay,
        StGap,
        StDone
    } state_e;

    localparam note_t NoteEnd = '{half: 12'd0, len: 3'd0};

`ifdef SOUND_MELODY_EN
    localparam int unsigned NotesPerTone = 8;

    localparam note_t TONE_ROM [NumTones][NotesPerTone] = '{
        '{{12'd100, 3'd1}, NoteEnd, NoteEnd, NoteEnd,
          NoteEnd, NoteEnd, NoteEnd, NoteEnd},
        '{{12'd50, 3'd2}, NoteEnd, NoteEnd, NoteEnd,
          NoteEnd, NoteEnd, NoteEnd, NoteEnd},
        '{{12'd120, 3'd1}, {12'd100, 3'd1}, {12'd80, 3'd1}, {12'd60, 3'd2},
          NoteEnd, NoteEnd, NoteEnd, NoteEnd},
        '{{12'd60, 3'd1}, {12'd0, 3'd1}, {12'd120, 3'd2}, NoteEnd,
          NoteEnd, NoteEnd, NoteEnd, NoteEnd}
    };
`else
    localparam int unsigned NotesPerTone = 1;

    localparam note_t TONE_ROM [NumTones][NotesPerTone] = '{
        '{{12'd100, 3'd1}},
        '{{12'd50, 3'd2}},
        '{{12'd120, 3'd1}},
        '{{12'd60, 3'd1}}
    };
`endif

endpackage

// File: rtl/tone_gen.sv
// Prescaled half-period square-wave divider.
//
// Ports:
//   clk, resetN - clock, asynchronous active-low reset
//   restart_i   - clears the divider and forces wave_o low
//   half_i      - half-period in units of PRESCALE clk cycles; 0 holds wave_o low
//   enable_i    - divider advances only while high
//   wave_o      - square wave, toggles every half_i*PRESCALE enabled cycles
module tone_gen
    import sound_pkg::*;
#(
    parameter int unsigned PRESCALE = 64
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             restart_i,
    input  logic [HalfW-1:0] half_i,
    input  logic             enable_i,
    output logic             wave_o
);

    localparam int unsigned PsW  = $clog2(PRESCALE + 1);
    localparam int unsigned CntW = HalfW + PsW;

    logic [CntW-1:0] period;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            wave_q, wave_d;

    assign period = CntW'(half_i) * CntW'(PRESCALE);

    always_comb begin
        cnt_d  = cnt_q;
        wave_d = wave_q;
        if (restart_i) begin
            cnt_d  = '0;
            wave_d = 1'b0;
        end else if (enable_i && (half_i != '0)) begin
            if (cnt_q == period - CntW'(1)) begin
                cnt_d  = '0;
                wave_d = ~wave_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q  <= '0;
            wave_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wave_q <= wave_d;
        end
    end

    assign wave_o = wave_q;

endmodule

// File: rtl/sound_sequencer.sv
// Tone sequencer: plays a tone from the tone table as a series of square-wave
// notes, each followed by a silent gap, and accepts one queued request while busy.
//
// Ports:
//   clk, resetN - clock, asynchronous active-low reset
//   playSound   - request pulse; toneSel is sampled with it
//   toneSel     - tone ID (0 countdown, 1 go, 2 welcome, 3 game-over)
//   mute        - level, forces soundOut low without stopping the sequencer
//   soundOut    - square-wave audio
//   busy        - high whenever the sequencer is not idle
//   done        - one-cycle pulse as a tone finishes
//
// Build option: SOUND_MELODY_EN plays every table entry of a tone; without it
// each tone ends after its first note.
module sound_sequencer
    import sound_pkg::*;
#(
    parameter int unsigned NOTE_TICKS = 12500000,
    parameter int unsigned GAP_TICKS  = 250000,
    parameter int unsigned PRESCALE   = 64
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       playSound,
    input  logic [1:0] toneSel,
    input  logic       mute,
    output logic       soundOut,
    output logic       busy,
    output logic       done
);

    localparam int unsigned TickW = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
    localparam int unsigned GapW  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

    localparam logic [TickW-1:0] TickReload = TickW'(NOTE_TICKS - 1);
    localparam logic [GapW-1:0]  GapReload  = GapW'(GAP_TICKS - 1);

    state_e            state_q, state_d;
    tone_e             tone_q, tone_d;
    logic              pend_q, pend_d;
    tone_e             pend_tone_q, pend_tone_d;
    logic [HalfW-1:0]  half_q, half_d;
    logic [LenW-1:0]   unit_q, unit_d;
    logic [TickW-1:0]  tick_q, tick_d;
    logic [GapW-1:0]   gap_q, gap_d;
    note_t             note;
    logic              wave;

`ifdef SOUND_MELODY_EN
    logic [2:0]        idx_q, idx_d;

    assign note = TONE_ROM[tone_q][idx_q];
`else
    assign note = TONE_ROM[tone_q][0];
`endif

    always_comb begin
        state_d     = state_q;
        tone_d      = tone_q;
        pend_d      = pend_q;
        pend_tone_d = pend_tone_q;
        half_d      = half_q;
        unit_d      = unit_q;
        tick_d      = tick_q;
        gap_d       = gap_q;
`ifdef SOUND_MELODY_EN
        idx_d       = idx_q;
`endif

        // Requests arriving mid-tone are queued; the newest one wins.
        if ((state_q != StIdle) && playSound) begin
            pend_d      = 1'b1;
            pend_tone_d = tone_e'(toneSel);
        end

        unique case (state_q)
            StIdle: begin
                if (playSound) begin
                    tone_d  = tone_e'(toneSel);
`ifdef SOUND_MELODY_EN
                    idx_d   = '0;
`endif
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (note.len == '0) begin
                    state_d = StDone;
                end else begin
                    half_d  = note.half;
                    unit_d  = note.len;
                    tick_d  = TickReload;
                    state_d = StPlay;
                end
            end
            StPlay: begin
                if (tick_q == '0) begin
                    tick_d = TickReload;
                    unit_d = unit_q - LenW'(1);
                    if (unit_q == LenW'(1)) begin
                        gap_d   = GapReload;
                        state_d = StGap;
                    end
                end else begin
                    tick_d = tick_q - TickW'(1);
                end
            end
            StGap: begin
                if (gap_q == '0) begin
`ifdef SOUND_MELODY_EN
                    if (idx_q == 3'd7) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = StLoad;
                    end
`else
                    state_d = StDone;
`endif
                end else begin
                    gap_d = gap_q - GapW'(1);
                end
            end
            StDone: begin
                // A request in this very cycle counts as queued, so chain straight on.
                if (pend_q || playSound) begin
                    tone_d  = playSound ? tone_e'(toneSel) : pend_tone_q;
                    pend_d  = 1'b0;
`ifdef SOUND_MELODY_EN
                    idx_d   = '0;
`endif
                    state_d = StLoad;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= StIdle;
            tone_q      <= ToneCountdown;
            pend_q      <= 1'b0;
            pend_tone_q <= ToneCountdown;
            half_q      <= '0;
            unit_q      <= '0;
            tick_q      <= '0;
            gap_q       <= '0;
`ifdef SOUND_MELODY_EN
            idx_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            tone_q      <= tone_d;
            pend_q      <= pend_d;
            pend_tone_q <= pend_tone_d;
            half_q      <= half_d;
            unit_q      <= unit_d;
            tick_q      <= tick_d;
            gap_q       <= gap_d;
`ifdef SOUND_MELODY_EN
            idx_q       <= idx_d;
`endif
        end
    end

    // Restart during LOAD so the wave starts low on the first PLAY cycle.
    tone_gen #(
        .PRESCALE(PRESCALE)
    ) u_tone_gen (
        .clk      (clk),
        .resetN   (resetN),
        .restart_i(state_q == StLoad),
        .half_i   (half_q),
        .enable_i (state_q == StPlay),
        .wave_o   (wave)
    );

    assign soundOut = wave && (state_q == StPlay) && !mute;
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);

endmodule

// File: tb/tb_sound_sequencer.sv
module tb_sound_sequencer;

    localparam int unsigned NT = 1000;
    localparam int unsigned GT = 2;
    localparam int unsigned PS = 1;

`ifdef SOUND_MELODY_EN
    localparam int XL      = 1;
    localparam int T2Busy  = 5014;
    localparam int T2Edges = 64;
    localparam int T3Busy  = 4011;
    localparam int T3Edges = 32;
`else
    localparam int XL      = 0;
    localparam int T2Busy  = 1004;
    localparam int T2Edges = 8;
    localparam int T3Busy  = 1004;
    localparam int T3Edges = 16;
`endif

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       playSound = 1'b0;
    logic [1:0] toneSel = 2'd0;
    logic       mute = 1'b0;
    logic       soundOut, busy, done;

    int checks = 0;
    int failures = 0;

    int   m_busy, m_dones, m_done_k, m_edges;
    int   m_edge_k [128];
    logic m_busy0;

    sound_sequencer #(
        .NOTE_TICKS(NT),
        .GAP_TICKS (GT),
        .PRESCALE  (PS)
    ) dut (
        .clk      (clk),
        .resetN   (resetN),
        .playSound(playSound),
        .toneSel  (toneSel),
        .mute     (mute),
        .soundOut (soundOut),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Starts a request (held for 'hold' cycles), optionally injects two more,
    // and records the busy run. k = 0 is the cycle after the request edge.
    task automatic measure(input logic [1:0] tone, input int hold,
                           input int inj0_k, input logic [1:0] inj0_tone,
                           input int inj1_k, input logic [1:0] inj1_tone);
        int   k;
        logic prev;
        m_busy = 0; m_dones = 0; m_done_k = -1; m_edges = 0; m_busy0 = 1'b0;
        prev = 1'b0;
        for (int i = 0; i < 128; i++) m_edge_k[i] = -1;
        @(posedge clk); #1;
        playSound = 1'b1; toneSel = tone;
        @(posedge clk); #1;
        if (hold <= 1) playSound = 1'b0;
        k = 0;
        while (k < 8000) begin
            @(negedge clk);
            if (k == 0) m_busy0 = busy;
            if (!busy) break;
            m_busy++;
            if (done) begin
                if (m_done_k < 0) m_done_k = k;
                m_dones++;
            end
            if (soundOut !== prev) begin
                if (m_edges < 128) m_edge_k[m_edges] = k;
                m_edges++;
            end
            prev = soundOut;
            playSound = ((k + 2) <= hold) || (k == inj0_k) || (k == inj1_k);
            if (k == inj0_k) toneSel = inj0_tone;
            if (k == inj1_k) toneSel = inj1_tone;
            k++;
        end
        playSound = 1'b0;
        if (k >= 8000) begin
            checks++; failures++;
            $display("FAIL measure_timeout busy still high after %0d cycles, required low", k);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (soundOut !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got soundOut=%b busy=%b done=%b, required 0 0 0",
                     soundOut, busy, done);
        end
        repeat (3) @(posedge clk);
        #1 resetN = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle busy=%b required 0", busy);
        end
    endtask

    task automatic test_tone0();
        int bad;
        measure(2'd0, 1, -1, 2'd0, -1, 2'd0);
        checks++;
        if (m_busy0 !== 1'b1) begin
            failures++; $display("FAIL tone0_latency busy=%b required 1", m_busy0);
        end
        checks++;
        if (m_busy != 1004 + XL) begin
            failures++; $display("FAIL tone0_busy got=%0d exp=%0d", m_busy, 1004 + XL);
        end
        checks++;
        if (m_dones != 1 || m_done_k != 1003 + XL) begin
            failures++;
            $display("FAIL tone0_done count=%0d at=%0d exp 1 at %0d", m_dones, m_done_k, 1003 + XL);
        end
        checks++;
        if (m_edges != 10 || m_edge_k[0] != 101 || m_edge_k[9] != 1001) begin
            failures++;
            $display("FAIL tone0_edges n=%0d first=%0d last=%0d exp 10 101 1001",
                     m_edges, m_edge_k[0], m_edge_k[9]);
        end
        bad = 0;
        for (int i = 1; i < 10; i++) if (m_edge_k[i] - m_edge_k[i-1] != 100) bad++;
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL tone0_spacing bad_intervals=%0d exp 0", bad);
        end
    endtask

    task automatic test_tone1();
        measure(2'd1, 1, -1, 2'd0, -1, 2'd0);
        checks++;
        if (m_busy != 2004 + XL || m_dones != 1) begin
            failures++;
            $display("FAIL tone1_busy got=%0d dones=%0d exp %0d 1", m_busy, m_dones, 2004 + XL);
        end
        checks++;
        if (m_edges != 40 || m_edge_k[0] != 51 || m_edge_k[39] != 2001) begin
            failures++;
            $display("FAIL tone1_edges n=%0d first=%0d last=%0d exp 40 51 2001",
                     m_edges, m_edge_k[0], m_edge_k[39]);
        end
    endtask

    task automatic test_melody();
        measure(2'd2, 1, -1, 2'd0, -1, 2'd0);
        checks++;
        if (m_busy != T2Busy || m_done_k != T2Busy - 1) begin
            failures++;
            $display("FAIL tone2_busy got=%0d done_at=%0d exp %0d %0d",
                     m_busy, m_done_k, T2Busy, T2Busy - 1);
        end
        checks++;
        if (m_edges != T2Edges || m_edge_k[0] != 121 || m_edge_k[1] != 241) begin
            failures++;
            $display("FAIL tone2_note1 n=%0d e0=%0d e1=%0d exp %0d 121 241",
                     m_edges, m_edge_k[0], m_edge_k[1], T2Edges);
        end
`ifdef SOUND_MELODY_EN
        checks++;
        if (m_edge_k[8] != 1104 || m_edge_k[9] != 1204 || m_edge_k[18] != 2087 ||
            m_edge_k[19] != 2167 || m_edge_k[30] != 3070 || m_edge_k[31] != 3130 ||
            m_edge_k[63] != 5010) begin
            failures++;
            $display("FAIL tone2_notes e8=%0d e9=%0d e18=%0d e19=%0d e30=%0d e31=%0d e63=%0d exp 1104 1204 2087 2167 3070 3130 5010",
                     m_edge_k[8], m_edge_k[9], m_edge_k[18], m_edge_k[19],
                     m_edge_k[30], m_edge_k[31], m_edge_k[63]);
        end
`endif
    endtask

    task automatic test_rest();
        measure(2'd3, 1, -1, 2'd0, -1, 2'd0);
        checks++;
        if (m_busy != T3Busy || m_edges != T3Edges || m_edge_k[15] != 961) begin
            failures++;
            $display("FAIL tone3 busy=%0d edges=%0d e15=%0d exp %0d %0d 961",
                     m_busy, m_edges, m_edge_k[15], T3Busy, T3Edges);
        end
`ifdef SOUND_MELODY_EN
        checks++;
        if (m_edge_k[16] != 2127 || m_edge_k[31] != 3927) begin
            failures++;
            $display("FAIL tone3_rest e16=%0d e31=%0d exp 2127 3927", m_edge_k[16], m_edge_k[31]);
        end
`endif
    endtask

    task automatic test_back_to_back();
        measure(2'd1, 1, 500, 2'd0, -1, 2'd0);
        checks++;
        if (m_busy != 3008 + 2 * XL || m_dones != 2 || m_done_k != 2003 + XL) begin
            failures++;
            $display("FAIL b2b busy=%0d dones=%0d first_done=%0d exp %0d 2 %0d",
                     m_busy, m_dones, m_done_k, 3008 + 2 * XL, 2003 + XL);
        end
        checks++;
        if (m_edges != 50 || m_edge_k[40] != 2105 + XL) begin
            failures++;
            $display("FAIL b2b_second n=%0d e40=%0d exp 50 %0d", m_edges, m_edge_k[40], 2105 + XL);
        end
    endtask

    task automatic test_overwrite();
        measure(2'd0, 1, 200, 2'd1, 300, 2'd2);
        checks++;
        if (m_busy != 1004 + XL + T2Busy || m_dones != 2) begin
            failures++;
            $display("FAIL overwrite_busy got=%0d dones=%0d exp %0d 2",
                     m_busy, m_dones, 1004 + XL + T2Busy);
        end
        checks++;
        if (m_edges != 10 + T2Edges || m_edge_k[10] != 1125 + XL) begin
            failures++;
            $display("FAIL overwrite_tone n=%0d e10=%0d exp %0d %0d",
                     m_edges, m_edge_k[10], 10 + T2Edges, 1125 + XL);
        end
    endtask

    task automatic test_hold();
        measure(2'd0, 3, -1, 2'd0, -1, 2'd0);
        checks++;
        if (m_busy != 2008 + 2 * XL || m_dones != 2 || m_edges != 20) begin
            failures++;
            $display("FAIL hold busy=%0d dones=%0d edges=%0d exp %0d 2 20",
                     m_busy, m_dones, m_edges, 2008 + 2 * XL);
        end
    endtask

    task automatic test_mute();
        mute = 1'b1;
        measure(2'd2, 1, -1, 2'd0, -1, 2'd0);
        mute = 1'b0;
        checks++;
        if (m_edges != 0) begin
            failures++; $display("FAIL mute_silent edges=%0d exp 0", m_edges);
        end
        checks++;
        if (m_done_k != T2Busy - 1 || m_busy != T2Busy) begin
            failures++;
            $display("FAIL mute_timing done_at=%0d busy=%0d exp %0d %0d",
                     m_done_k, m_busy, T2Busy - 1, T2Busy);
        end
    endtask

    task automatic test_reset_mid();
        int stray;
        @(posedge clk); #1;
        playSound = 1'b1; toneSel = 2'd0;
        @(posedge clk); #1;
        playSound = 1'b0;
        repeat (351) @(negedge clk);
        checks++;
        if (soundOut !== 1'b1) begin
            failures++; $display("FAIL reset_mid_pre soundOut=%b exp 1", soundOut);
        end
        #2 resetN = 1'b0;
        #1;
        checks++;
        if (soundOut !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_async soundOut=%b busy=%b done=%b exp 0 0 0",
                     soundOut, busy, done);
        end
        stray = 0;
        repeat (3) @(negedge clk) if (done || busy) stray++;
        #1 resetN = 1'b1;
        repeat (1100) @(negedge clk) if (done || busy) stray++;
        checks++;
        if (stray != 0) begin
            failures++; $display("FAIL reset_mid_quiet active_samples=%0d exp 0", stray);
        end
        measure(2'd0, 1, -1, 2'd0, -1, 2'd0);
        checks++;
        if (m_busy != 1004 + XL || m_edges != 10 || m_dones != 1) begin
            failures++;
            $display("FAIL reset_mid_replay busy=%0d edges=%0d dones=%0d exp %0d 10 1",
                     m_busy, m_edges, m_dones, 1004 + XL);
        end
    endtask

    initial begin
        test_reset();
        test_tone0();
        test_tone1();
        test_melody();
        test_rest();
        test_back_to_back();
        test_overwrite();
        test_hold();
        test_mute();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog simulation time limit reached, required bench completion");
        $fatal(1);
    end

endmodule
